symb_exam: RTL and testbench

SYMB_EXAM -- requirements
Module: symb_exam

---
 rtl/symb_exam_pkg.sv | 23 ++
 rtl/symb_sat_add.sv | 44 ++++
 rtl/symb_exam.sv | 53 +++++
 tb/tb_symb_exam.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/symb_exam_pkg.sv
// Shared width and saturation limits for the symb_exam saturating adders.
package symb_exam_pkg;

  localparam int W_DEF = 4;

  // Limits as plain integers so any width can derive its own constants.
  function automatic int smax_of(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  function automatic int smin_of(input int w);
    return -(2 ** (w - 1));
  endfunction

  function automatic int umax_of(input int w);
    return (2 ** w) - 1;
  endfunction

  localparam int SMAX = smax_of(W_DEF);
  localparam int SMIN = smin_of(W_DEF);
  localparam int UMAX = umax_of(W_DEF);

endpackage

// File: rtl/symb_sat_add.sv
// Combinational W-bit saturating adder; SIGNED_MODE picks two's-complement
// or unsigned interpretation of the operands.
module symb_sat_add
  import symb_exam_pkg::*;
#(
  parameter int W           = W_DEF,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [W-1:0] SAT_HI_S = W'(smax_of(W));
  localparam logic [W-1:0] SAT_LO_S = W'(smin_of(W));
  localparam logic [W-1:0] SAT_HI_U = W'(umax_of(W));

  logic [W:0] ext_sum;

  // NOTE: every output of an always_comb block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ext_sum = '0;
    sum     = '0;
    ovf     = 1'b0;
    if (SIGNED_MODE) begin
      ext_sum = {a[W-1], a} + {b[W-1], b};
      // The W+1-bit result overflowed when its top two bits disagree.
      ovf     = ext_sum[W] ^ ext_sum[W-1];
      if (!ovf)
        sum = ext_sum[W-1:0];
      else if (ext_sum[W])
        sum = SAT_LO_S;
      else
        sum = SAT_HI_S;
    end else begin
      ext_sum = {1'b0, a} + {1'b0, b};
      ovf     = ext_sum[W];
      sum     = ovf ? SAT_HI_U : ext_sum[W-1:0];
    end
  end

endmodule

// File: rtl/symb_exam.sv
// Registered signed and unsigned saturating sums of two W-bit operands,
// one clock of latency, synchronous active-high reset.
module symb_exam
  import symb_exam_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  output logic [W-1:0] signed_out,
  output logic [W-1:0] unsigned_out,
  output logic         signed_ovf,
  output logic         unsigned_ovf
);

  logic [W-1:0] s_sum;
  logic [W-1:0] u_sum;
  logic         s_ovf;
  logic         u_ovf;

  symb_sat_add #(.W(W), .SIGNED_MODE(1'b1)) u_signed_add (
    .a   (d1),
    .b   (d2),
    .sum (s_sum),
    .ovf (s_ovf)
  );

  symb_sat_add #(.W(W), .SIGNED_MODE(1'b0)) u_unsigned_add (
    .a   (d1),
    .b   (d2),
    .sum (u_sum),
    .ovf (u_ovf)
  );

  // NOTE: registered state uses non-blocking assignments so all four
  // outputs update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      signed_out   <= '0;
      unsigned_out <= '0;
      signed_ovf   <= 1'b0;
      unsigned_ovf <= 1'b0;
    end else begin
      signed_out   <= s_sum;
      unsigned_out <= u_sum;
      signed_ovf   <= s_ovf;
      unsigned_ovf <= u_ovf;
    end
  end

endmodule

// File: tb/tb_symb_exam.sv
// Self-checking bench for symb_exam: directed corner cases plus random
// back-to-back operands against an integer-arithmetic reference model.
module tb_symb_exam;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d1  = '0;
  logic [3:0] d2  = '0;
  logic [3:0] signed_out;
  logic [3:0] unsigned_out;
  logic       signed_ovf;
  logic       unsigned_ovf;

  int errors = 0;
  int checks = 0;

  symb_exam #(.W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .d1           (d1),
    .d2           (d2),
    .signed_out   (signed_out),
    .unsigned_out (unsigned_out),
    .signed_ovf   (signed_ovf),
    .unsigned_ovf (unsigned_ovf)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {unsigned_out, signed_out, unsigned_ovf, signed_ovf}.
  logic [9:0] obs;
  assign obs = {unsigned_out, signed_out, unsigned_ovf, signed_ovf};

  // Reference: plain integer sums, clamped to the representable ranges.
  function automatic logic [9:0] model(input int a, input int b);
    int   us, sa, sb, ss, uo, so;
    logic uovf, sovf;
    us   = a + b;
    uovf = (us > 15);
    uo   = uovf ? 15 : us;
    sa   = (a > 7) ? a - 16 : a;
    sb   = (b > 7) ? b - 16 : b;
    ss   = sa + sb;
    sovf = (ss > 7) || (ss < -8);
    so   = (ss > 7) ? 7 : ((ss < -8) ? -8 : ss);
    return {4'(uo), 4'(so), uovf, sovf};
  endfunction

  // Apply one operand pair and move to just after the capturing edge.
  task automatic drive_cycle(input int a, input int b);
    d1 = 4'(a);
    d2 = 4'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_cycle(5, 5);
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_zero: got %b expected %b", obs, 10'b0);
    end
    rst = 1'b0;
    drive_cycle(5, 5);
    checks++;
    if (obs !== {4'd10, 4'd7, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs, {4'd10, 4'd7, 1'b0, 1'b1});
    end
  endtask

  task automatic test_sweep();
    logic [9:0] exp;
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(i, 1);
      exp = {4'(i + 1), 4'(i + 1), 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sweep d1=%0d: got %b expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_signed_ovf();
    int         a_tab [3] = '{7, 7, 4};
    int         b_tab [3] = '{1, 4, 6};
    logic [3:0] u_tab [3] = '{4'd8, 4'd11, 4'd10};
    logic [9:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(a_tab[i], b_tab[i]);
      exp = {u_tab[i], 4'd7, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL signed_ovf %0d+%0d: got %b expected %b", a_tab[i], b_tab[i], obs, exp);
      end
    end
  endtask

  task automatic test_both_clamp();
    drive_cycle(8, 15);
    checks++;
    if (obs !== {4'd15, 4'b1000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL both_clamp: got %b expected %b", obs, {4'd15, 4'b1000, 1'b1, 1'b1});
    end
  endtask

  task automatic test_wrap();
    drive_cycle(15, 1);
    checks++;
    if (obs !== {4'd15, 4'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap: got %b expected %b", obs, {4'd15, 4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_midstream_reset();
    drive_cycle(7, 7);
    rst = 1'b1;
    drive_cycle(9, 9);
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL midstream_reset: got %b expected %b", obs, 10'b0);
    end
    rst = 1'b0;
    drive_cycle(3, 2);
    checks++;
    if (obs !== {4'd5, 4'd5, 2'b00}) begin
      errors++;
      $display("FAIL after_midstream_reset: got %b expected %b", obs, {4'd5, 4'd5, 2'b00});
    end
  endtask

  task automatic test_back_to_back();
    int         a, b;
    logic [9:0] prev_exp;
    logic [9:0] exp;
    prev_exp = model(3, 2);
    for (int i = 0; i < 16; i++) begin
      a  = int'($urandom_range(15));
      b  = int'($urandom_range(15));
      d1 = 4'(a);
      d2 = 4'(b);
      #2;
      // New operands must not reach the outputs before the next edge.
      checks++;
      if (obs !== prev_exp) begin
        errors++;
        $display("FAIL hold_%0d: got %b expected %b", i, obs, prev_exp);
      end
      @(posedge clk);
      #1;
      exp = model(a, b);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_%0d %0d+%0d: got %b expected %b", i, a, b, obs, exp);
      end
      prev_exp = exp;
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_signed_ovf();
    test_both_clamp();
    test_wrap();
    test_midstream_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
